// File: rtl/command_executor.sv
// Runs one decoded UART command at a time against the data memory.
// Each command ends in an ack byte, four read-data bytes (LSB first) or an error byte.
module command_executor #(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int TX_TIMEOUT  = 2047
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_done,
    input  logic [1:0]            cmd_error,
    input  logic                  cmd_readwrite,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_start,
    input  logic                  tx_busy,
    output logic                  o_busy,
    output logic [1:0]            o_status,
    output logic                  o_dropped
);

    localparam int              TO_W     = $clog2(TX_TIMEOUT + 1);
    localparam logic [1:0]      LAT_LAST = 2'(MEM_LATENCY - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TX_TIMEOUT);
    localparam logic [7:0]      ACK_BYTE = 8'hAA;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR      = 4'd1,
        RD_EN   = 4'd2,
        RD_WAIT = 4'd3,
        ACK_TX  = 4'd4,
        ERR_TX  = 4'd5,
        DATA_TX = 4'd6,
        TX_HOLD = 4'd7,
        TX_WAIT = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  rd_q, rd_d;
    logic [1:0]            err_q, err_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [1:0]            status_q, status_d;
    logic                  dropped_q, dropped_d;

    function automatic logic [7:0] pick_byte(input logic [DATA_WIDTH-1:0] word,
                                             input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            err_q     <= 2'b00;
            idx_q     <= 2'd0;
            lat_cnt_q <= 2'd0;
            to_cnt_q  <= '0;
            tx_byte_q <= 8'h00;
            status_q  <= 2'b00;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            lat_cnt_q <= lat_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tx_byte_q <= tx_byte_d;
            status_q  <= status_d;
            dropped_q <= dropped_d;
        end
    end

    // Read data is only meaningful after capture, so it carries no reset.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rd_d      = rd_q;
        err_d     = err_q;
        idx_d     = idx_q;
        lat_cnt_d = lat_cnt_q;
        to_cnt_d  = to_cnt_q;
        tx_byte_d = tx_byte_q;
        status_d  = status_q;
        dropped_d = cmd_done && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (cmd_done) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_data;
                    rd_d    = cmd_readwrite;
                    err_d   = cmd_error;
                    if (cmd_error != 2'b00) begin
                        state_d   = ERR_TX;
                        tx_byte_d = {6'b111000, cmd_error};
                    end else if (cmd_readwrite) begin
                        state_d = RD_EN;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                state_d   = ACK_TX;
                tx_byte_d = ACK_BYTE;
            end
            RD_EN: begin
                state_d   = RD_WAIT;
                lat_cnt_d = 2'd0;
            end
            RD_WAIT: begin
                // Capture lands exactly MEM_LATENCY edges after the strobe cycle.
                if (lat_cnt_q == LAT_LAST) begin
                    shift_d   = mem_rdata;
                    idx_d     = 2'd0;
                    tx_byte_d = mem_rdata[7:0];
                    state_d   = DATA_TX;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ACK_TX, ERR_TX, DATA_TX: begin
                if (!tx_busy) begin
                    state_d = TX_HOLD;
                end
            end
            TX_HOLD: begin
                state_d  = TX_WAIT;
                to_cnt_d = '0;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (rd_q && (err_q == 2'b00) && (idx_q != 2'd3)) begin
                        idx_d     = idx_q + 2'd1;
                        tx_byte_d = pick_byte(shift_q, idx_q + 2'd1);
                        state_d   = DATA_TX;
                    end else begin
                        state_d = DONE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    status_d = 2'b11;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            DONE: begin
                if (err_q != 2'b00) begin
                    status_d = 2'b10;
                end else if (rd_q) begin
                    status_d = 2'b01;
                end else begin
                    status_d = 2'b00;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_mem_en    = (state_q == WR) || (state_q == RD_EN);
        o_mem_we    = (state_q == WR);
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        o_tx_byte   = tx_byte_q;
        o_tx_start  = ((state_q == ACK_TX) || (state_q == ERR_TX) || (state_q == DATA_TX))
                      && !tx_busy;
        o_busy      = (state_q != IDLE);
        o_status    = status_q;
        o_dropped   = dropped_q;
    end

endmodule

// File: tb/tb_command_executor.sv
// Directed bench for command_executor: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
`timescale 1ns/1ps
module tb_command_executor;

    localparam int          TO   = 30;
    localparam logic [31:0] JUNK = 32'hBAD0F00D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_done = 1'b0;
    logic        cmd_done3 = 1'b0;
    logic [1:0]  cmd_error = 2'b00;
    logic        cmd_readwrite = 1'b0;
    logic [14:0] cmd_address = '0;
    logic [31:0] cmd_data = '0;
    logic        tx_stuck = 1'b0;
    logic        tx_busy3 = 1'b0;
    logic [3:0]  tx_cnt = 4'd0;
    logic        tx_busy;
    int          tx_len = 0;
    int          cyc = 0;

    logic        en1, we1, start1, busy1, drop1;
    logic [14:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic [7:0]  byte1;
    logic [1:0]  status1;
    logic        en3, we3, start3, busy3, drop3;
    logic [14:0] addr3;
    logic [31:0] wdata3, rdata3;
    logic [7:0]  byte3;
    logic [1:0]  status3;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    command_executor #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .MEM_LATENCY(1), .TX_TIMEOUT(TO)) u_dut1 (
        .clock(clock), .reset(reset), .cmd_done(cmd_done), .cmd_error(cmd_error),
        .cmd_readwrite(cmd_readwrite), .cmd_address(cmd_address), .cmd_data(cmd_data),
        .o_mem_en(en1), .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_wdata(wdata1),
        .mem_rdata(rdata1), .o_tx_byte(byte1), .o_tx_start(start1), .tx_busy(tx_busy),
        .o_busy(busy1), .o_status(status1), .o_dropped(drop1)
    );

    command_executor #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .MEM_LATENCY(3), .TX_TIMEOUT(TO)) u_dut3 (
        .clock(clock), .reset(reset), .cmd_done(cmd_done3), .cmd_error(cmd_error),
        .cmd_readwrite(cmd_readwrite), .cmd_address(cmd_address), .cmd_data(cmd_data),
        .o_mem_en(en3), .o_mem_we(we3), .o_mem_addr(addr3), .o_mem_wdata(wdata3),
        .mem_rdata(rdata3), .o_tx_byte(byte3), .o_tx_start(start3), .tx_busy(tx_busy3),
        .o_busy(busy3), .o_status(status3), .o_dropped(drop3)
    );

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return (a == 15'h0005) ? 32'h11223344 : ({17'h0, a} ^ 32'h5A5A0000);
    endfunction

    // Memory models: data is valid only in the exact latency slot, junk otherwise.
    logic        p1_v = 1'b0;
    logic [31:0] p1_d = '0;
    logic [2:0]  p3_v = 3'b000;
    logic [31:0] p3_d [0:2];
    always @(posedge clock) begin
        p1_v    <= en1 && !we1;
        p1_d    <= mem_word(addr1);
        p3_v    <= {p3_v[1:0], en3 && !we3};
        p3_d[0] <= mem_word(addr3);
        p3_d[1] <= p3_d[0];
        p3_d[2] <= p3_d[1];
    end
    assign rdata1 = p1_v ? p1_d : JUNK;
    assign rdata3 = p3_v[2] ? p3_d[2] : JUNK;

    // Transmitter model: busy for tx_len cycles after each start, or stuck.
    always @(posedge clock or posedge reset) begin
        if (reset)            tx_cnt <= 4'd0;
        else if (start1)      tx_cnt <= 4'(tx_len);
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 4'd1;
    end
    assign tx_busy = tx_stuck || (tx_cnt != 4'd0);

    logic [7:0]  bytes1[$];
    int          scyc1[$];
    int          ecyc1[$];
    logic [14:0] eaddr1[$];
    logic [31:0] ewd1[$];
    logic        ewe1[$];
    int          drops1 = 0;
    int          busy_cnt1 = 0;
    logic [7:0]  bytes3[$];
    int          scyc3[$];
    int          en3_cnt = 0;
    int          we3_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (start1) begin bytes1.push_back(byte1); scyc1.push_back(cyc); end
            if (en1) begin
                ecyc1.push_back(cyc); eaddr1.push_back(addr1);
                ewd1.push_back(wdata1); ewe1.push_back(we1);
            end
            if (drop1) drops1 = drops1 + 1;
            if (busy1) busy_cnt1 = busy_cnt1 + 1;
            if (start3) begin bytes3.push_back(byte3); scyc3.push_back(cyc); end
            if (en3) en3_cnt = en3_cnt + 1;
            if (en3 && we3) we3_cnt = we3_cnt + 1;
        end
    end

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int t_edge = 0;
    int b_bytes, b_en, b_busy, b_drops, b_bytes3, b_en3, b_we3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [1:0] err, input logic [14:0] a,
                         input logic [31:0] d, input logic to3);
        @(posedge clock); #1;
        b_bytes = bytes1.size(); b_en = ecyc1.size(); b_busy = busy_cnt1; b_drops = drops1;
        b_bytes3 = bytes3.size(); b_en3 = en3_cnt; b_we3 = we3_cnt;
        cmd_readwrite = rw; cmd_error = err; cmd_address = a; cmd_data = d;
        if (to3) cmd_done3 = 1'b1; else cmd_done = 1'b1;
        t_edge = cyc + 1;
        @(posedge clock); #1;
        cmd_done = 1'b0; cmd_done3 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input logic use3);
        int n = 0;
        while ((use3 ? busy3 : busy1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(tag, {63'b0, use3 ? busy3 : busy1}, 64'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        #2;
        chk("reset_ctrl1", {en1, we1, start1, busy1, drop1, status1, byte1}, 64'd0);
        chk("reset_addr_data1", {addr1, wdata1}, 64'd0);
        chk("reset_ctrl3", {en3, start3, busy3, status3, byte3}, 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Decoder error on a read: error byte only, no memory access.
        issue(1'b1, 2'b01, 15'h0007, 32'h0, 1'b0);
        wait_idle("err_idle", 1'b0);
        chk("err_no_mem_en", ecyc1.size() - b_en, 0);
        chk("err_nbytes", bytes1.size() - b_bytes, 1);
        chk("err_byte", bytes1[b_bytes], 8'hE1);
        chk("err_start_cycle", scyc1[b_bytes] - t_edge + 1, 1);
        chk("err_busy_cycles", busy_cnt1 - b_busy, 4);
        chk("err_status", status1, 2'b10);

        // Write.
        issue(1'b0, 2'b00, 15'h1234, 32'hDEADBEEF, 1'b0);
        wait_idle("wr_idle", 1'b0);
        chk("wr_en_count", ecyc1.size() - b_en, 1);
        chk("wr_we", ewe1[b_en], 1'b1);
        chk("wr_addr", eaddr1[b_en], 15'h1234);
        chk("wr_wdata", ewd1[b_en], 32'hDEADBEEF);
        chk("wr_en_cycle", ecyc1[b_en] - t_edge + 1, 1);
        chk("wr_nbytes", bytes1.size() - b_bytes, 1);
        chk("wr_ack_byte", bytes1[b_bytes], 8'hAA);
        chk("wr_start_cycle", scyc1[b_bytes] - t_edge + 1, 2);
        chk("wr_busy_cycles", busy_cnt1 - b_busy, 5);
        chk("wr_status", status1, 2'b00);

        // Read at latency 1 with a slow transmitter.
        tx_len = 2;
        issue(1'b1, 2'b00, 15'h0005, 32'h0, 1'b0);
        wait_idle("rd1_idle", 1'b0);
        tx_len = 0;
        chk("rd1_nbytes", bytes1.size() - b_bytes, 4);
        chk("rd1_bytes", {bytes1[b_bytes], bytes1[b_bytes+1], bytes1[b_bytes+2], bytes1[b_bytes+3]},
            32'h44332211);
        chk("rd1_en_count", ecyc1.size() - b_en, 1);
        chk("rd1_no_we", ewe1[b_en], 1'b0);
        chk("rd1_first_start", scyc1[b_bytes] - t_edge + 1, 3);
        chk("rd1_gap", scyc1[b_bytes+2] - scyc1[b_bytes+1], 4);
        chk("rd1_status", status1, 2'b01);

        // Read at latency 3, idle transmitter.
        issue(1'b1, 2'b00, 15'h0005, 32'h0, 1'b1);
        wait_idle("rd3_idle", 1'b1);
        chk("rd3_nbytes", bytes3.size() - b_bytes3, 4);
        chk("rd3_bytes", {bytes3[b_bytes3], bytes3[b_bytes3+1], bytes3[b_bytes3+2], bytes3[b_bytes3+3]},
            32'h44332211);
        chk("rd3_first_start", scyc3[b_bytes3] - t_edge + 1, 5);
        chk("rd3_gap", scyc3[b_bytes3+1] - scyc3[b_bytes3], 3);
        chk("rd3_en_we", {en3_cnt - b_en3, we3_cnt - b_we3}, {32'd1, 32'd0});
        chk("rd3_status", status3, 2'b01);

        // Second command two cycles after the first is dropped.
        issue(1'b0, 2'b00, 15'h0022, 32'h55667788, 1'b0);
        @(posedge clock); #1;
        cmd_readwrite = 1'b1; cmd_address = 15'h0033; cmd_done = 1'b1;
        @(posedge clock); #1;
        cmd_done = 1'b0;
        wait_idle("drop_idle", 1'b0);
        chk("drop_pulse", drops1 - b_drops, 1);
        chk("drop_en_count", ecyc1.size() - b_en, 1);
        chk("drop_addr", eaddr1[b_en], 15'h0022);
        chk("drop_nbytes", bytes1.size() - b_bytes, 1);
        chk("drop_byte", bytes1[b_bytes], 8'hAA);
        chk("drop_status", status1, 2'b00);
        chk("drop_held_addr_data", {addr1, wdata1}, {15'h0022, 32'h55667788});

        // Command arriving in the DONE cycle is dropped too.
        issue(1'b0, 2'b00, 15'h0044, 32'h12345678, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        cmd_readwrite = 1'b1; cmd_address = 15'h0066; cmd_done = 1'b1;
        @(posedge clock); #1;
        cmd_done = 1'b0;
        wait_idle("done_drop_idle", 1'b0);
        repeat (3) @(negedge clock);
        chk("done_drop_pulse", drops1 - b_drops, 1);
        chk("done_drop_en_count", ecyc1.size() - b_en, 1);
        chk("done_drop_busy", busy1, 1'b0);

        // Transmitter stuck after the second read byte: timeout abort.
        issue(1'b1, 2'b00, 15'h0005, 32'h0, 1'b0);
        n = 0;
        while (!(start1 && byte1 == 8'h33) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("to_second_byte_seen", n < 100, 1'b1);
        @(posedge clock); #1;
        tx_stuck = 1'b1;
        m = 0;
        do begin
            @(negedge clock);
            if (busy1) m++;
        end while (busy1 && m < TO + 20);
        chk("to_busy_after_start", m, TO + 2);
        repeat (2) @(negedge clock);
        chk("to_nbytes", bytes1.size() - b_bytes, 2);
        chk("to_bytes", {bytes1[b_bytes], bytes1[b_bytes+1]}, 16'h4433);
        chk("to_status", status1, 2'b11);
        chk("to_busy", busy1, 1'b0);
        tx_stuck = 1'b0;

        issue(1'b0, 2'b00, 15'h000A, 32'h0BADCAFE, 1'b0);
        wait_idle("post_to_idle", 1'b0);
        chk("post_to_nbytes", bytes1.size() - b_bytes, 1);
        chk("post_to_byte", bytes1[b_bytes], 8'hAA);
        chk("post_to_wdata", ewd1[b_en], 32'h0BADCAFE);
        chk("post_to_status", status1, 2'b00);

        // Asynchronous reset during RD_WAIT.
        issue(1'b1, 2'b00, 15'h0005, 32'h0, 1'b0);
        @(posedge clock); #1;
        chk("rst_pre_busy", busy1, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_ctrl", {en1, we1, start1, busy1, drop1, status1, byte1}, 64'd0);
        chk("rst_async_addr_data", {addr1, wdata1}, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        chk("rst_no_start_after", bytes1.size() - b_bytes, 0);
        chk("rst_idle_after", busy1, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
